// File: rtl/regwr_arb_pkg.sv
// regwr_arb_pkg: shared types and widths for the register-file write arbiter.
`default_nettype none

package regwr_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 4;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_W0   = 2'b01,
    ST_W1   = 2'b10,
    ST_W1F  = 2'b11
  } wr_src_e;

endpackage

`default_nettype wire

// File: rtl/regwr_starve_ctr.sv
// regwr_starve_ctr: saturating loss counter for the low-priority write requester.
`default_nettype none

module regwr_starve_ctr
  import regwr_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: two-requester arbiter onto a single register-file write port.
// Define REGWR_ARB_STARVE_EN to enable the Req1 anti-starvation counter.
`default_nettype none

module regwr_arbiter
  import regwr_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req0Valid,
  input  logic [REG_ADDR_W-1:0] Req0Reg,
  input  logic [DATA_W-1:0]     Req0Data,
  output logic                  Req0Ready,
  input  logic                  Req1Valid,
  input  logic [REG_ADDR_W-1:0] Req1Reg,
  input  logic [DATA_W-1:0]     Req1Data,
  output logic                  Req1Ready,
  output logic                  RegWriteEn,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  output logic [1:0]            WrSrc
);

  wr_src_e               r_state;
  wr_src_e               w_state_nxt;
  logic                  w_force;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer;
  logic [REG_ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0]     w_sel_data;
  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0]     r_wdata;

`ifdef REGWR_ARB_STARVE_EN
  logic w_ctr_inc;
  logic w_ctr_clr;
  logic w_ctr_sat;

  assign w_ctr_inc = Req1Valid & w_grant0;
  assign w_ctr_clr = w_grant1 | ~Req1Valid;

  regwr_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .i_inc (w_ctr_inc),
    .i_clr (w_ctr_clr),
    .o_sat (w_ctr_sat)
  );

  assign w_force = w_ctr_sat & Req1Valid;
`else
  logic w_unused_starve_cfg;

  assign w_unused_starve_cfg = (STARVE_LIMIT != 0);
  assign w_force             = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_state_nxt = ST_IDLE;
    if (w_force) begin
      w_grant1    = 1'b1;
      w_state_nxt = ST_W1F;
    end else if (Req0Valid) begin
      w_grant0    = 1'b1;
      w_state_nxt = ST_W0;
    end else if (Req1Valid) begin
      w_grant1    = 1'b1;
      w_state_nxt = ST_W1;
    end
  end

  // Ready is masked by reset so neither requester sees an acceptance while held in reset.
  assign Req0Ready = w_grant0 & Rst_n;
  assign Req1Ready = w_grant1 & Rst_n;

  assign w_xfer     = w_grant0 | w_grant1;
  assign w_sel_reg  = w_grant1 ? Req1Reg  : Req0Reg;
  assign w_sel_data = w_grant1 ? Req1Data : Req0Data;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wen   <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_xfer && (w_sel_reg != ZERO_REG);
      if (w_xfer) begin
        r_wreg  <= w_sel_reg;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign RegWriteEn = r_wen;
  assign WriteReg   = r_wreg;
  assign WriteData  = r_wdata;
  assign WrSrc      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: directed self-checking bench for regwr_arbiter.
`default_nettype none

module tb_regwr_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        Req0Valid;
  logic [4:0]  Req0Reg;
  logic [31:0] Req0Data;
  logic        Req0Ready;
  logic        Req1Valid;
  logic [4:0]  Req1Reg;
  logic [31:0] Req1Data;
  logic        Req1Ready;
  logic        RegWriteEn;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [1:0]  WrSrc;

  int n_cmp = 0;
  int n_err = 0;

  regwr_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req0Valid  (Req0Valid),
    .Req0Reg    (Req0Reg),
    .Req0Data   (Req0Data),
    .Req0Ready  (Req0Ready),
    .Req1Valid  (Req1Valid),
    .Req1Reg    (Req1Reg),
    .Req1Data   (Req1Data),
    .Req1Ready  (Req1Ready),
    .RegWriteEn (RegWriteEn),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .WrSrc      (WrSrc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic wen, input logic [4:0] wreg,
                         input logic [31:0] wdata, input logic [1:0] src);
    chk({tag, ".wen"},   {31'd0, RegWriteEn}, {31'd0, wen});
    chk({tag, ".wreg"},  {27'd0, WriteReg},   {27'd0, wreg});
    chk({tag, ".wdata"}, WriteData,           wdata);
    chk({tag, ".wrsrc"}, {30'd0, WrSrc},      {30'd0, src});
  endtask

  initial begin
    logic exp_r1;

    Rst_n = 1'b0;
    Req0Valid = 1'b1; Req0Reg = 5'd4; Req0Data = 32'h1111_1111;
    Req1Valid = 1'b1; Req1Reg = 5'd6; Req1Data = 32'h2222_2222;

    // Held in reset with both requesters active
    #3;
    chk("rst.ready0", {31'd0, Req0Ready}, 32'd0);
    chk("rst.ready1", {31'd0, Req1Ready}, 32'd0);
    chk_out("rst", 1'b0, 5'd0, 32'd0, 2'b00);
    @(posedge Clk); #1;
    chk_out("rst_edge", 1'b0, 5'd0, 32'd0, 2'b00);

    // Req0 only, first cycle after reset release
    @(negedge Clk);
    Rst_n = 1'b1;
    Req0Valid = 1'b1; Req0Reg = 5'd5; Req0Data = 32'hA5A5_A5A5;
    Req1Valid = 1'b0;
    #1;
    chk("r0only.ready0", {31'd0, Req0Ready}, 32'd1);
    chk("r0only.ready1", {31'd0, Req1Ready}, 32'd0);
    @(posedge Clk); #1;
    chk_out("r0only", 1'b1, 5'd5, 32'hA5A5_A5A5, 2'b01);

    // Both target reg 3: Req0 wins first, Req1 follows
    @(negedge Clk);
    Req0Valid = 1'b1; Req0Reg = 5'd3; Req0Data = 32'd1;
    Req1Valid = 1'b1; Req1Reg = 5'd3; Req1Data = 32'd2;
    #1;
    chk("same.ready0", {31'd0, Req0Ready}, 32'd1);
    chk("same.ready1", {31'd0, Req1Ready}, 32'd0);
    @(posedge Clk); #1;
    chk_out("same.w0", 1'b1, 5'd3, 32'd1, 2'b01);
    @(negedge Clk);
    Req0Valid = 1'b0;
    #1;
    chk("same.ready1b", {31'd0, Req1Ready}, 32'd1);
    @(posedge Clk); #1;
    chk_out("same.w1", 1'b1, 5'd3, 32'd2, 2'b10);

    // Idle: enable drops, address/data hold
    @(negedge Clk);
    Req1Valid = 1'b0;
    #1;
    chk("idle.ready1", {31'd0, Req1Ready}, 32'd0);
    @(posedge Clk); #1;
    chk_out("idle", 1'b0, 5'd3, 32'd2, 2'b00);

    // Req1 to $zero: accepted but never written
    @(negedge Clk);
    Req1Valid = 1'b1; Req1Reg = 5'd0; Req1Data = 32'hFFFF_FFFF;
    #1;
    chk("zero.ready1", {31'd0, Req1Ready}, 32'd1);
    @(posedge Clk); #1;
    chk("zero.wen",   {31'd0, RegWriteEn}, 32'd0);
    chk("zero.wrsrc", {30'd0, WrSrc},      32'd2);

    // Both continuously valid: starvation behaviour
    @(negedge Clk);
    Req0Valid = 1'b1; Req0Reg = 5'd10; Req0Data = 32'h0000_00A0;
    Req1Valid = 1'b1; Req1Reg = 5'd11; Req1Data = 32'h0000_00B1;
    for (int k = 0; k < 10; k++) begin
`ifdef REGWR_ARB_STARVE_EN
      exp_r1 = ((k % 5) == 4);
`else
      exp_r1 = 1'b0;
`endif
      #1;
      chk($sformatf("starve%0d.ready1", k), {31'd0, Req1Ready}, {31'd0, exp_r1});
      chk($sformatf("starve%0d.ready0", k), {31'd0, Req0Ready}, {31'd0, ~exp_r1});
      @(posedge Clk); #1;
      chk($sformatf("starve%0d.wrsrc", k), {30'd0, WrSrc}, exp_r1 ? 32'd3 : 32'd1);
      chk($sformatf("starve%0d.wreg", k), {27'd0, WriteReg}, exp_r1 ? 32'd11 : 32'd10);
      @(negedge Clk);
    end

    // Reset in the cycle after a transfer discards the pending write
    Req0Valid = 1'b1; Req0Reg = 5'd7; Req0Data = 32'h0000_1234;
    Req1Valid = 1'b0;
    @(posedge Clk); #1;
    chk_out("pre_rst", 1'b1, 5'd7, 32'h0000_1234, 2'b01);
    Rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 5'd0, 32'd0, 2'b00);
    chk("mid_rst.ready0", {31'd0, Req0Ready}, 32'd0);
    @(posedge Clk); #1;
    chk_out("mid_rst_edge", 1'b0, 5'd0, 32'd0, 2'b00);

    // Recovery: Req1 granted right after release
    @(negedge Clk);
    Rst_n = 1'b1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b1; Req1Reg = 5'd9; Req1Data = 32'hCAFE_0009;
    #1;
    chk("recov.ready1", {31'd0, Req1Ready}, 32'd1);
    @(posedge Clk); #1;
    chk_out("recov", 1'b1, 5'd9, 32'hCAFE_0009, 2'b10);

    @(negedge Clk);
    Req1Valid = 1'b0;
    @(posedge Clk); #1;
    chk_out("final_idle", 1'b0, 5'd9, 32'hCAFE_0009, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
